// File: rtl/kypd_pkg.sv
// kypd_pkg: shared types and lookup tables for the 4x4 keypad scan controller.
// Rev 1.0
`default_nettype none

package kypd_pkg;

  typedef enum logic [0:0] {
    ST_SCAN = 1'b0,
    ST_EVAL = 1'b1
  } kypd_state_e;

  // Keypad legend indexed by scan position 4*column + row (row 0 is the top row).
  localparam logic [3:0] C_KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  // Note frequency in Hz indexed by key code.
  localparam logic [11:0] C_FREQ_TBL [16] = '{
    12'd392, 12'd523, 12'd349, 12'd262,
    12'd494, 12'd330, 12'd247, 12'd440,
    12'd294, 12'd220, 12'd175, 12'd165,
    12'd147, 12'd131, 12'd196, 12'd262
  };

  localparam logic [11:0] C_RESET_FREQ = 12'd440;

endpackage

`default_nettype wire

// File: rtl/kypd_evt_fifo.sv
// kypd_evt_fifo: small synchronous event FIFO, valid/ready pop side, sticky overflow on dropped push.
// Rev 1.0
`default_nettype none

module kypd_evt_fifo
  import kypd_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr_en;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push when popping.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = !w_empty && i_ready;
    w_wr_en = i_push && (!w_full || w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/kypd_scan_ctrl.sv
// kypd_scan_ctrl: 4x4 keypad column scan, per-key debounce, event FIFO and held note frequency.
// Define KYPD_RELEASE_EVT_EN to also queue release events.  Rev 1.0
`default_nettype none

module kypd_scan_ctrl
  import kypd_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100000,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Row,
  output logic [3:0]  Col,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [3:0]  evt_key,
  output logic        evt_press,
  output logic [11:0] freq,
  output logic        overflow
);

  localparam int             CW       = $clog2(SCAN_CYCLES);
  localparam logic [CW-1:0]  C_LAST   = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0]  C_SAMPLE = CW'(SETTLE_CYCLES);
  localparam logic [3:0]     C_DEB    = 4'(DEBOUNCE_SCANS);

  kypd_state_e   r_state, w_state_nxt;
  logic [1:0]    r_cidx, w_cidx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_idx, w_idx_nxt;
  logic [3:0]    r_col, w_col_nxt;

  logic [3:0]    r_row_s1, r_row_s2;
  logic [3:0]    r_raw [4];
  logic [15:0]   r_stable;
  logic [3:0]    r_dcnt [16];
  logic [11:0]   r_freq;

  logic [1:0]    w_rsel;
  logic [3:0]    w_raw_col;
  logic          w_raw_press;
  logic          w_differ;
  logic [3:0]    w_dcnt_inc;
  logic          w_commit;
  logic [3:0]    w_key;
  logic          w_push;
  logic [4:0]    w_fifo_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SCAN;
      r_cidx  <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_col   <= 4'hF;
    end else begin
      r_state <= w_state_nxt;
      r_cidx  <= w_cidx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_col   <= w_col_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cidx_nxt  = r_cidx;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_SCAN: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nxt = '0;
          if (r_cidx == 2'd3) begin
            w_state_nxt = ST_EVAL;
            w_idx_nxt   = '0;
          end else begin
            w_cidx_nxt = r_cidx + 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_EVAL: begin
        w_idx_nxt = r_idx + 4'd1;
        if (r_idx == 4'd15) begin
          w_state_nxt = ST_SCAN;
          w_cidx_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
    // Col is registered from the next state so the drive lines up with the phase counter.
    w_col_nxt = (w_state_nxt == ST_SCAN) ? ~(4'b1000 >> w_cidx_nxt) : 4'hF;
  end

  always_comb begin
    w_rsel      = ~r_idx[1:0];
    w_raw_col   = r_raw[r_idx[3:2]];
    w_raw_press = ~w_raw_col[w_rsel];
    w_differ    = (w_raw_press != r_stable[r_idx]);
    w_dcnt_inc  = r_dcnt[r_idx] + 4'd1;
    w_commit    = (r_state == ST_EVAL) && w_differ && (w_dcnt_inc == C_DEB);
    w_key       = C_KEY_MAP[r_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
      r_stable <= '0;
      r_freq   <= C_RESET_FREQ;
      for (int k = 0; k < 4; k++)  r_raw[k]  <= 4'hF;
      for (int k = 0; k < 16; k++) r_dcnt[k] <= '0;
    end else begin
      r_row_s1 <= Row;
      r_row_s2 <= r_row_s1;
      if (r_state == ST_SCAN && r_cnt == C_SAMPLE) r_raw[r_cidx] <= r_row_s2;
      if (r_state == ST_EVAL) begin
        if (!w_differ) begin
          r_dcnt[r_idx] <= '0;
        end else if (w_commit) begin
          r_dcnt[r_idx]   <= '0;
          r_stable[r_idx] <= w_raw_press;
        end else begin
          r_dcnt[r_idx] <= w_dcnt_inc;
        end
      end
      if (w_commit && w_raw_press) r_freq <= C_FREQ_TBL[w_key];
    end
  end

`ifdef KYPD_RELEASE_EVT_EN
  assign w_push = w_commit;
`else
  assign w_push = w_commit && w_raw_press;
`endif

  assign w_fifo_data = {w_raw_press, w_key};

  kypd_evt_fifo #(
    .WIDTH (5),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_data     (w_fifo_data),
    .o_valid    (evt_valid),
    .i_ready    (evt_ready),
    .o_data     ({evt_press, evt_key}),
    .o_overflow (overflow)
  );

  assign Col  = r_col;
  assign freq = r_freq;

endmodule

`default_nettype wire
